// File: rtl/fsgn_pipe_if.sv
// Request/result bundle for the FP sign-manipulation pipe.
// master drives requests and consumes results; slave is the unit itself.
interface fsgn_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 5
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [W-1:0]     x;
  logic [W-1:0]     z;
  logic [TAG_W-1:0] tag_in;
  logic [W-1:0]     y;
  logic             out_valid;
  logic             out_ready;
  logic [TAG_W-1:0] tag_out;
  logic             nan_flag;
  logic             illegal;

  modport master (
    output in_valid, op, x, z, tag_in, out_ready,
    input  in_ready, y, out_valid, tag_out, nan_flag, illegal
  );

  modport slave (
    input  in_valid, op, x, z, tag_in, out_ready,
    output in_ready, y, out_valid, tag_out, nan_flag, illegal
  );
endinterface

// File: rtl/fsgn_pipe.sv
// FP sign unit (FABS/FNEG/FSGNJ/FSGNJN/FSGNJX/FMV) with a LATENCY-deep
// valid/ready pipeline; stage 1 computes, later stages only carry data.
module fsgn_pipe #(
  parameter int EXP_W   = 8,
  parameter int MAN_W   = 23,
  parameter int LATENCY = 2,
  parameter int TAG_W   = 5
) (
  input  logic         sys_clk,
  input  logic         rstn,
  fsgn_pipe_if.slave   bus
);
  localparam int W = 1 + EXP_W + MAN_W;

  generate
    if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
      $error("fsgn_pipe: LATENCY must be in 1..4");
    end
  endgenerate

  typedef struct packed {
    logic [W-1:0]     y;
    logic [TAG_W-1:0] tag;
    logic             nan;
    logic             ill;
  } rsp_t;

  rsp_t                 res;
  rsp_t [LATENCY:1]     stg;
  logic [LATENCY:1]     vld_pipe;
  logic [LATENCY:1]     adv;
  logic                 run;
  logic                 s;
  logic                 unused_z;

  // Only the sign of z ever matters.
  assign unused_z = ^bus.z[W-2:0];

  always_comb begin
    s = bus.x[W-1];
    case (bus.op)
      3'd0:    s = 1'b0;
      3'd1:    s = ~bus.x[W-1];
      3'd2:    s = bus.z[W-1];
      3'd3:    s = ~bus.z[W-1];
      3'd4:    s = bus.x[W-1] ^ bus.z[W-1];
      default: s = bus.x[W-1];
    endcase
    res.y   = {s, bus.x[W-2:0]};
    res.tag = bus.tag_in;
    res.ill = (bus.op[2:1] == 2'b11);
    res.nan = (&bus.x[W-2:MAN_W]) & (|bus.x[MAN_W-1:0]);
  end

  // Ready ripples back from the output: a stage moves if any stage at or
  // after it is empty, or the consumer takes the head.
  always_comb begin
    run = bus.out_ready;
    adv = '0;
    for (int k = LATENCY; k >= 1; k--) begin
      run    = run | ~vld_pipe[k];
      adv[k] = run;
    end
  end

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      vld_pipe <= '0;
      stg      <= '0;
    end else begin
      if (adv[1]) begin
        vld_pipe[1] <= bus.in_valid;
        stg[1]      <= res;
      end
      for (int k = 2; k <= LATENCY; k++) begin
        if (adv[k]) begin
          vld_pipe[k] <= vld_pipe[k-1];
          stg[k]      <= stg[k-1];
        end
      end
    end
  end

  assign bus.in_ready  = adv[1] & rstn;
  assign bus.out_valid = vld_pipe[LATENCY];
  assign bus.y         = stg[LATENCY].y;
  assign bus.tag_out   = stg[LATENCY].tag;
  assign bus.nan_flag  = stg[LATENCY].nan;
  assign bus.illegal   = stg[LATENCY].ill;
endmodule

// File: tb/tb_fsgn_pipe.sv
// Self-checking bench for fsgn_pipe: directed ops, backpressure, random
// traffic against a queue-based reference model, and mid-flight reset.
module tb_fsgn_pipe;
  localparam int EXP_W   = 8;
  localparam int MAN_W   = 23;
  localparam int LATENCY = 2;
  localparam int TAG_W   = 5;
  localparam int W       = 1 + EXP_W + MAN_W;

  logic sys_clk = 1'b0;
  logic rstn;
  always #5 sys_clk = ~sys_clk;

  fsgn_pipe_if #(.EXP_W(EXP_W), .MAN_W(MAN_W), .TAG_W(TAG_W)) bus ();

  fsgn_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .LATENCY(LATENCY), .TAG_W(TAG_W)) dut (
    .sys_clk (sys_clk),
    .rstn    (rstn),
    .bus     (bus)
  );

  typedef struct {
    logic [W-1:0]     y;
    logic [TAG_W-1:0] tag;
    logic             nan;
    logic             ill;
    int               t;
  } exp_t;

  exp_t q[$];
  int   cyc_n, total, bad;
  logic o_ir, e_ir, o_ov, e_ov, popped;
  exp_t got, want;

  // Reference result from the sign rules, expressed as mask arithmetic on the word.
  function automatic exp_t ref_res(input logic [2:0] op, input logic [W-1:0] x,
                                   input logic [W-1:0] z, input logic [TAG_W-1:0] tag);
    exp_t r;
    logic [W-1:0] sb;
    sb = '0;
    sb[W-1] = 1'b1;
    r.tag = tag;
    r.ill = (op >= 3'd6);
    r.nan = (x[W-2:MAN_W] == '1) && (x[MAN_W-1:0] != '0);
    r.t   = 0;
    case (op)
      3'd0:    r.y = x & ~sb;
      3'd1:    r.y = x ^ sb;
      3'd2:    r.y = (x & ~sb) | (z & sb);
      3'd3:    r.y = (x & ~sb) | (~z & sb);
      3'd4:    r.y = x ^ (z & sb);
      default: r.y = x;
    endcase
    return r;
  endfunction

  // One clock of traffic: drive at the falling edge, observe, update the model.
  task automatic step(input logic iv, input logic [2:0] op, input logic [W-1:0] x,
                      input logic [W-1:0] z, input logic [TAG_W-1:0] tag, input logic ordy);
    exp_t n;
    @(negedge sys_clk);
    bus.in_valid = iv; bus.op = op; bus.x = x; bus.z = z;
    bus.tag_in = tag; bus.out_ready = ordy;
    #1;
    o_ir   = bus.in_ready;
    e_ir   = (q.size() < LATENCY) || ordy;
    o_ov   = bus.out_valid;
    e_ov   = (q.size() > 0) && (cyc_n - q[0].t >= LATENCY);
    popped = 1'b0;
    if (e_ov && ordy) begin
      popped  = 1'b1;
      want    = q.pop_front();
      got.y   = bus.y;   got.tag = bus.tag_out;
      got.nan = bus.nan_flag; got.ill = bus.illegal; got.t = 0;
    end
    if (e_ir && iv) begin
      n   = ref_res(op, x, z, tag);
      n.t = cyc_n;
      q.push_back(n);
    end
    cyc_n++;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(posedge sys_clk);
    #2;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
    total++; if (bus.y !== '0) begin bad++; $display("FAIL rst_y got=%h exp=0", bus.y); end
    total++; if (bus.tag_out !== '0) begin bad++; $display("FAIL rst_tag got=%h exp=0", bus.tag_out); end
    total++; if ({bus.nan_flag, bus.illegal} !== 2'b00) begin bad++; $display("FAIL rst_flags got=%b exp=00", {bus.nan_flag, bus.illegal}); end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b exp=0", bus.in_ready); end
    @(negedge sys_clk);
    rstn = 1'b1;
  endtask

  task automatic test_ops();
    logic [2:0]       ops [10] = '{3'd0, 3'd2, 3'd4, 3'd1, 3'd0, 3'd6, 3'd3, 3'd5, 3'd7, 3'd2};
    logic [W-1:0]     xs  [10] = '{32'hC0490FDB, 32'h3F800000, 32'hBF800000, 32'h00000000, 32'hFFC00001,
                                   32'h12345678, 32'h3F800000, 32'hFF800001, 32'h80000000, 32'h7FC00000};
    logic [W-1:0]     zs  [10] = '{32'h0, 32'h80000000, 32'h80000000, 32'h0, 32'h0,
                                   32'h0, 32'h80000000, 32'h0, 32'h0, 32'hFFFFFFFF};
    logic [TAG_W-1:0] tgs [10] = '{5'd3, 5'd1, 5'd2, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd31, 5'd9};
    logic [W-1:0]     ys  [10] = '{32'h40490FDB, 32'hBF800000, 32'h3F800000, 32'h80000000, 32'h7FC00001,
                                   32'h12345678, 32'h3F800000, 32'hFF800001, 32'h80000000, 32'hFFC00000};
    logic             ns  [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic             is  [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    int pi = 0;
    for (int i = 0; i < 10 + LATENCY + 2; i++) begin
      int idx = (i < 10) ? i : 0;
      step(i < 10, ops[idx], xs[idx], zs[idx], tgs[idx], 1'b1);
      total++; if (o_ir !== e_ir) begin bad++; $display("FAIL ops_in_ready cyc=%0d got=%b exp=%b", i, o_ir, e_ir); end
      total++; if (o_ov !== e_ov) begin bad++; $display("FAIL ops_out_valid cyc=%0d got=%b exp=%b", i, o_ov, e_ov); end
      if (popped) begin
        total++;
        if ({got.y, got.tag, got.nan, got.ill} !== {ys[pi], tgs[pi], ns[pi], is[pi]}) begin
          bad++;
          $display("FAIL ops_result #%0d got y=%h tag=%0d nan=%b ill=%b exp y=%h tag=%0d nan=%b ill=%b",
                   pi, got.y, got.tag, got.nan, got.ill, ys[pi], tgs[pi], ns[pi], is[pi]);
        end
        total++;
        if ({got.y, got.tag, got.nan, got.ill} !== {want.y, want.tag, want.nan, want.ill}) begin
          bad++;
          $display("FAIL ops_model #%0d got y=%h exp y=%h", pi, got.y, want.y);
        end
        pi++;
      end
    end
    total++; if (pi != 10) begin bad++; $display("FAIL ops_count got=%0d exp=10", pi); end
  endtask

  task automatic test_backpressure();
    logic [W-1:0]     xs [7];
    logic [W-1:0]     y0;
    int               nxt = 1, acc = 0, etag = 1;
    logic             ordy;
    for (int i = 0; i < 7; i++) xs[i] = W'($urandom);
    y0 = '0;
    for (int c = 0; c < 60 && (nxt <= 6 || q.size() > 0); c++) begin
      ordy = (c >= 6);
      step(nxt <= 6, 3'd0, xs[(nxt <= 6) ? nxt : 0], '0, TAG_W'(nxt), ordy);
      if (o_ir && nxt <= 6) acc++;
      if (e_ir && nxt <= 6) nxt++;
      total++; if (o_ir !== e_ir) begin bad++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=%b", c, o_ir, e_ir); end
      total++; if (o_ov !== e_ov) begin bad++; $display("FAIL bp_out_valid cyc=%0d got=%b exp=%b", c, o_ov, e_ov); end
      if (c == 2) y0 = bus.y;
      if (c >= 3 && c <= 5) begin
        total++;
        if (bus.y !== y0 || bus.tag_out !== TAG_W'(1)) begin
          bad++; $display("FAIL bp_stable cyc=%0d got y=%h tag=%0d exp y=%h tag=1", c, bus.y, bus.tag_out, y0);
        end
      end
      if (c == 5) begin
        total++; if (acc != LATENCY) begin bad++; $display("FAIL bp_accepts got=%0d exp=%0d", acc, LATENCY); end
      end
      if (popped) begin
        total++;
        if ({got.y, got.tag, got.nan, got.ill} !== {want.y, TAG_W'(etag), want.nan, want.ill}) begin
          bad++; $display("FAIL bp_order got y=%h tag=%0d exp y=%h tag=%0d", got.y, got.tag, want.y, etag);
        end
        etag++;
      end
    end
    total++; if (etag != 7 || q.size() != 0) begin bad++; $display("FAIL bp_drain got=%0d exp=7 left=%0d", etag - 1 + 1, q.size()); end
  endtask

  task automatic test_random();
    int acc = 0, c = 0;
    logic [63:0]  r;
    logic [W-1:0] x;
    logic         iv;
    while ((acc < 1000 || q.size() > 0) && c < 20000) begin
      r = {$urandom, $urandom};
      x = r[W-1:0];
      if ($urandom_range(0, 7) == 0) x[W-2:MAN_W] = '1;
      iv = (acc < 1000) && ($urandom_range(0, 9) < 7);
      step(iv, 3'($urandom_range(0, 7)), x, W'($urandom), TAG_W'($urandom), $urandom_range(0, 9) < 6);
      if (iv && e_ir) acc++;
      total++; if (o_ir !== e_ir) begin bad++; $display("FAIL rnd_in_ready cyc=%0d got=%b exp=%b", c, o_ir, e_ir); end
      total++; if (o_ov !== e_ov) begin bad++; $display("FAIL rnd_out_valid cyc=%0d got=%b exp=%b", c, o_ov, e_ov); end
      if (popped) begin
        total++;
        if ({got.y, got.tag, got.nan, got.ill} !== {want.y, want.tag, want.nan, want.ill}) begin
          bad++;
          $display("FAIL rnd_result cyc=%0d got y=%h tag=%0d nan=%b ill=%b exp y=%h tag=%0d nan=%b ill=%b",
                   c, got.y, got.tag, got.nan, got.ill, want.y, want.tag, want.nan, want.ill);
        end
      end
      c++;
    end
    total++; if (acc < 1000 || q.size() != 0) begin bad++; $display("FAIL rnd_timeout accepted=%0d exp=1000 left=%0d", acc, q.size()); end
  endtask

  task automatic test_reset_midflight();
    step(1'b1, 3'd1, 32'h11111111, '0, 5'd10, 1'b0);
    step(1'b1, 3'd1, 32'h22222222, '0, 5'd11, 1'b0);
    step(1'b0, 3'd0, '0, '0, '0, 1'b0);
    total++; if (o_ov !== e_ov) begin bad++; $display("FAIL mid_pre_valid got=%b exp=%b", o_ov, e_ov); end
    #2;
    rstn = 1'b0;
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL mid_async_valid got=%b exp=0", bus.out_valid); end
    total++; if (bus.y !== '0) begin bad++; $display("FAIL mid_async_y got=%h exp=0", bus.y); end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL mid_in_ready got=%b exp=0", bus.in_ready); end
    @(posedge sys_clk);
    @(negedge sys_clk);
    rstn = 1'b1;
    q.delete();
    for (int i = 0; i < LATENCY + 4; i++) begin
      step(1'b0, 3'd0, '0, '0, '0, 1'b1);
      total++; if (o_ov !== e_ov) begin bad++; $display("FAIL mid_stale cyc=%0d got=%b exp=%b", i, o_ov, e_ov); end
      total++; if (o_ir !== e_ir) begin bad++; $display("FAIL mid_ready cyc=%0d got=%b exp=%b", i, o_ir, e_ir); end
    end
  endtask

  initial begin
    total = 0; bad = 0; cyc_n = 0;
    bus.in_valid = 1'b0; bus.op = '0; bus.x = '0; bus.z = '0;
    bus.tag_in = '0; bus.out_ready = 1'b0;
    test_reset();
    test_ops();
    test_backpressure();
    test_random();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog expired at cycle %0d", cyc_n);
    $fatal(1, "watchdog");
  end
endmodule
